// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache and its miss/refill controller.
package cache_pkg;

    function automatic int offset_width(input int data_w, input int line_words);
        return $clog2(line_words * data_w / 8);
    endfunction

    localparam int CACHE_ADDR_W     = 32;
    localparam int CACHE_DATA_W     = 32;
    localparam int CACHE_LINE_WORDS = 16;
    localparam int CACHE_OFFSET_W   = offset_width(CACHE_DATA_W, CACHE_LINE_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FILL    = 3'd4
    } refill_state_t;

    typedef logic [CACHE_LINE_WORDS*CACHE_DATA_W-1:0] cache_line_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller: optional word-by-word victim write-back, then a
// word-by-word line read, returned to the cache as a single-cycle fill.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = CACHE_ADDR_W,
    parameter int DATA_W     = CACHE_DATA_W,
    parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [ADDR_W-1:0]            miss_addr,
    input  logic                         miss_dirty,
    input  logic [ADDR_W-1:0]            miss_victim_addr,
    input  logic [LINE_WORDS*DATA_W-1:0] miss_victim_data,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_rsp_valid,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         fill_valid,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [LINE_WORDS*DATA_W-1:0] fill_data,
    output logic                         busy
);

    localparam int LINE_W     = LINE_WORDS * DATA_W;
    localparam int CNT_W      = $clog2(LINE_WORDS);
    localparam int OFF_W      = offset_width(DATA_W, LINE_WORDS);
    localparam int BIT_IDX_W  = $clog2(LINE_W);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((32'd1 << OFF_W) - 32'd1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    refill_state_t          r_state;
    refill_state_t          w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [ADDR_W-1:0]      r_miss_base;
    logic [ADDR_W-1:0]      r_victim_base;
    logic [LINE_W-1:0]      r_victim_line;
    logic [LINE_W-1:0]      r_fill_line;
    logic                   w_accept;
    logic                   w_store;
    logic [ADDR_W-1:0]      w_word_off;
    logic [BIT_IDX_W-1:0]   w_bit_base;

    assign w_word_off = ADDR_W'(r_cnt) * WORD_BYTES;
    assign w_bit_base = BIT_IDX_W'(r_cnt) * BIT_IDX_W'(DATA_W);

    // State, word counter and the two line registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_miss_base   <= '0;
            r_victim_base <= '0;
            r_victim_line <= '0;
            r_fill_line   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_miss_base   <= miss_addr & ~OFF_MASK;
                r_victim_base <= miss_victim_addr & ~OFF_MASK;
                r_victim_line <= miss_victim_data;
            end
            if (w_store) begin
                r_fill_line[w_bit_base +: DATA_W] <= mem_rdata;
            end
        end
    end

    // Next-state and counter logic; responses outside RD_WAIT are ignored.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_store      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (miss_valid) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = '0;
                    w_next_state = miss_dirty ? ST_WB_REQ : ST_RD_REQ;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WB_REQ: begin
                if (mem_req_ready) begin
                    if (r_cnt == LAST_WORD) begin
                        w_cnt_next   = '0;
                        w_next_state = ST_RD_REQ;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1'b1);
                    end
                end else begin
                    w_next_state = ST_WB_REQ;
                end
            end
            ST_RD_REQ: begin
                if (mem_req_ready) begin
                    w_next_state = ST_RD_WAIT;
                end else begin
                    w_next_state = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rsp_valid) begin
                    w_store = 1'b1;
                    if (r_cnt == LAST_WORD) begin
                        w_next_state = ST_FILL;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_W'(1'b1);
                        w_next_state = ST_RD_REQ;
                    end
                end else begin
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_FILL: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Memory request decode; fields depend only on registers, so they hold while stalled.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (r_state)
            ST_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = r_victim_base + w_word_off;
                mem_wdata     = r_victim_line[w_bit_base +: DATA_W];
            end
            ST_RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = r_miss_base + w_word_off;
            end
            default: begin
                mem_req_valid = 1'b0;
            end
        endcase
    end

    assign miss_ready = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign fill_valid = (r_state == ST_FILL);
    assign fill_addr  = r_miss_base;
    assign fill_data  = r_fill_line;

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss/refill controller sitting directly downstream of the 2-way `cache` block, between it and main memory. It accepts one line-miss request at a time from the cache. If the victim is dirty, it first writes the victim line back word by word. It then reads the missing line word by word from memory and returns the assembled line to the cache as a single-cycle fill.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: memory word width; multiple of 8.
- `LINE_WORDS`, 16: words per line (64-byte line); power of two, ≥2.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `miss_valid` in 1: miss request from the cache.
- `miss_ready` out 1: controller can accept a miss.
- `miss_addr` in ADDR_W: byte address of the missing line; offset bits are ignored.
- `miss_dirty` in 1: victim line must be written back.
- `miss_victim_addr` in ADDR_W: victim line byte address; offset bits are ignored.
- `miss_victim_data` in LINE_WORDS*DATA_W: victim line; word i is at `[i*DATA_W +: DATA_W]`.
- `mem_req_valid` out 1: memory request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: word byte address.
- `mem_wdata` out DATA_W: write data.
- `mem_rsp_valid` in 1: read data returned.
- `mem_rdata` in DATA_W: read data.
- `fill_valid` out 1: one-cycle pulse; the fill line is valid.
- `fill_addr` out ADDR_W: line-aligned address of the filled line.
- `fill_data` out LINE_WORDS*DATA_W: filled line, in the same word layout as the victim.
- `busy` out 1: high whenever the FSM state is not IDLE.

## Operation
- FSM states: IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL.
- **IDLE**
  - `miss_ready`=1.
  - On `miss_valid && miss_ready`: capture the line-aligned `miss_addr`, the victim address and the victim data. Clear the word counter.
  - Go to WB_REQ if `miss_dirty`, else RD_REQ.
- **WB_REQ**
  - Drive `mem_req_valid`=1, `mem_we`=1, `mem_addr`=victim_base + i*(DATA_W/8), `mem_wdata`=victim word i.
  - On `mem_req_ready`: increment i. After word LINE_WORDS-1 is accepted, clear i and go to RD_REQ.
  - Writes have no response.
- **RD_REQ**
  - Drive `mem_req_valid`=1, `mem_we`=0, `mem_addr`=miss_base + i*(DATA_W/8).
  - On `mem_req_ready`: go to RD_WAIT.
- **RD_WAIT**
  - `mem_req_valid`=0.
  - On `mem_rsp_valid`: store `mem_rdata` into line word i. If i = LINE_WORDS-1, go to FILL; else increment i and go to RD_REQ.
- **FILL**
  - `fill_valid`=1 for exactly one cycle, with `fill_addr`=miss_base and `fill_data`=the assembled line.
  - Next state is IDLE unconditionally; the cache has no backpressure on fills.
- Request fields are stable while `mem_req_valid`=1 and not yet accepted.
- Words are issued in ascending order, word 0 first.
- Exactly one memory read is outstanding at a time.
- `mem_rsp_valid` outside RD_WAIT is ignored: no state change, no data capture.
- The word counter is log2(LINE_WORDS) bits and never wraps within a transfer.
- Address offset bits (log2(LINE_WORDS*DATA_W/8)) are forced to zero on capture.

## Timing
- Reset values:
  - state IDLE; `miss_ready`=1 (combinational from the IDLE state), `busy`=0.
  - `mem_req_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `fill_valid`=0, `fill_addr`=0, `fill_data`=0; counter 0.
- Reset asserted mid-transfer aborts the transfer immediately: no fill and no further requests. A read response arriving after reset is ignored.
- Memory response latency is ≥1 cycle after request acceptance. A response in the same cycle as acceptance is illegal.
- Clean miss, `mem_req_ready` held 1, response exactly 1 cycle after acceptance:
  - handshake in cycle 0;
  - word i requested in cycle 2i+1, its response in cycle 2i+2;
  - `fill_valid` in cycle 2*LINE_WORDS+1 (33 at default).
- Dirty miss under the same conditions adds LINE_WORDS cycles: `fill_valid` in cycle 49 at default.
- A new miss can be accepted no earlier than the cycle after FILL.

## Structure
- Shared package `cache_pkg` holds:
  - the `LINE_WORDS`, `DATA_W` and `ADDR_W` defaults;
  - the offset-width localparam;
  - the `refill_state_t` enum;
  - the `cache_line_t` packed line type.
- No sub-module: a single FSM, one counter and two line registers.

## Test plan
- **Clean miss:** memory model returns rdata = address with 3-cycle latency; miss_addr 0x00000040 clean. Required: 16 reads at 0x40..0x7C; `fill_valid` pulses once; `fill_addr`=0x40; fill word0=0x40, word15=0x7C.
- **Dirty miss:** miss_addr 0x00000000, victim 0x00000200, victim word0=0xDEADBEEF, other words = index. Required: 16 writes at 0x200..0x23C with word0 data DEADBEEF, all before the first read at 0x000; then fill.
- **Backpressure:** `mem_req_ready` toggles 0/1 every cycle. Required: `mem_addr`/`mem_wdata` stay stable while stalled; no word is duplicated or skipped; fill is correct.
- **Unaligned miss / miss while busy:** miss_addr 0x00000044 gives `fill_addr`=0x40. A second `miss_valid` held during the transfer sees `miss_ready`=0 and is accepted only the cycle after FILL.
- **Reset mid-transfer:** assert `rst` in RD_WAIT of word 5, then deliver `mem_rsp_valid` after reset. Required: outputs return to their reset values, no `fill_valid`, the late response is ignored, and a subsequent miss completes normally.
- **Spurious response:** `mem_rsp_valid` pulsed in IDLE. Required: no state change.
